// File: rtl/spi_frame_pkg.sv
// Shared constants and state encoding for the SPI frame loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spi_frame_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] CMD_WRITE     = 8'h01;
    localparam logic [7:0] CMD_EXEC      = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADL,
        ST_ADH,
        ST_LNL,
        ST_LNH,
        ST_DATA,
        ST_CHK
    } state_t;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_EXEC);
    endfunction

endpackage

// File: rtl/spi_frame_loader.sv
// Pops bytes from the SPI inbound FIFO, parses load frames, streams payload to memory.
// Latency: write/done/exec strobes appear one cycle after the byte that causes them is popped.
// Backpressure: pops only while d_avail_i and enable_i are high, never in consecutive cycles.
//
// Ports:
//   clk_i, reset_i         bus clock, asynchronous active-high reset
//   enable_i               loader enable; low aborts the frame and clears err_o
//   d_avail_i, data_i      FIFO not-empty flag and head byte
//   rd_o                   FIFO pop strobe
//   adr_o, data_o, wr_o    memory write port
//   exec_o, exec_adr_o     execute pulse and held start address
//   busy_o, done_o, err_o  frame in progress, good frame pulse, sticky error
module spi_frame_loader
    import spi_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int          ADR_W     = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             d_avail_i,
    input  logic [7:0]       data_i,
    output logic             rd_o,
    output logic [ADR_W-1:0] adr_o,
    output logic [7:0]       data_o,
    output logic             wr_o,
    output logic             exec_o,
    output logic [ADR_W-1:0] exec_adr_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    state_t           state_q, state_d;
    logic             rd_q;
    logic             en_q;
    logic [7:0]       cmd_q;
    logic [7:0]       len_lo_q;
    logic [15:0]      cnt_q;
    logic [7:0]       sum_q;
    logic [ADR_W-1:0] adr_q;
    logic [ADR_W-1:0] exec_adr_q;
    logic [7:0]       data_q;
    logic             wr_q;
    logic             done_q;
    logic             exec_q;
    logic             err_q;

    logic             pop;
    logic [15:0]      len_c;
    logic             bad_cmd_c;
    logic             bad_len_c;
    logic             chk_c;
    logic             chk_ok_c;

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every state consumes one byte per pop.
    always_comb begin
        state_d = state_q;
        if (pop) begin
            case (state_q)
                ST_IDLE: if (data_i == SYNC_BYTE) state_d = ST_CMD;
                ST_CMD:  state_d = cmd_known(data_i) ? ST_ADL : ST_IDLE;
                ST_ADL:  state_d = ST_ADH;
                ST_ADH:  state_d = ST_LNL;
                ST_LNL:  state_d = ST_LNH;
                ST_LNH: begin
                    if (bad_len_c)        state_d = ST_IDLE;
                    else if (len_c == '0) state_d = ST_CHK;
                    else                  state_d = ST_DATA;
                end
                ST_DATA: if (cnt_q == 16'd1) state_d = ST_CHK;
                ST_CHK:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        if (!enable_i) state_d = ST_IDLE;
    end

    // Output / event decode. The pop is held off for one cycle after each
    // pop so the FIFO flags settle; reset also masks it so rd_o is quiet.
    always_comb begin
        pop       = enable_i & d_avail_i & ~rd_q & ~reset_i;
        rd_o      = pop;
        busy_o    = (state_q != ST_IDLE);
        len_c     = {data_i, len_lo_q};
        bad_cmd_c = pop & (state_q == ST_CMD) & ~cmd_known(data_i);
        bad_len_c = pop & (state_q == ST_LNH) & (cmd_q == CMD_EXEC) & (len_c != '0);
        chk_c     = pop & (state_q == ST_CHK);
        chk_ok_c  = chk_c & (sum_q == data_i);
    end

    // Datapath: frame fields, checksum, payload stream and status flags.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_q       <= 1'b0;
            en_q       <= 1'b0;
            cmd_q      <= '0;
            len_lo_q   <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            adr_q      <= '0;
            exec_adr_q <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            exec_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_q   <= pop;
            en_q   <= enable_i;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            exec_q <= 1'b0;

            if (pop) begin
                case (state_q)
                    ST_IDLE: sum_q <= '0;
                    ST_CMD: begin
                        cmd_q <= data_i;
                        sum_q <= sum_q + data_i;
                    end
                    ST_ADL: begin
                        adr_q <= ADR_W'(data_i);
                        sum_q <= sum_q + data_i;
                    end
                    ST_ADH: begin
                        adr_q <= ADR_W'({data_i, adr_q[7:0]});
                        sum_q <= sum_q + data_i;
                    end
                    ST_LNL: begin
                        len_lo_q <= data_i;
                        sum_q    <= sum_q + data_i;
                    end
                    ST_LNH: begin
                        cnt_q <= len_c;
                        sum_q <= sum_q + data_i;
                    end
                    ST_DATA: begin
                        wr_q   <= 1'b1;
                        data_q <= data_i;
                        cnt_q  <= cnt_q - 16'd1;
                        sum_q  <= sum_q + data_i;
                    end
                    ST_CHK: begin
                        if (chk_ok_c) begin
                            done_q <= 1'b1;
                            if (cmd_q == CMD_EXEC) begin
                                exec_q     <= 1'b1;
                                exec_adr_q <= adr_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            // Address advances after the write it belongs to; wraps freely.
            if (wr_q) adr_q <= adr_q + ADR_W'(1);

            if (en_q & ~enable_i)
                err_q <= 1'b0;
            else if (bad_cmd_c | bad_len_c | (chk_c & ~chk_ok_c))
                err_q <= 1'b1;
        end
    end

    // Strobes are suppressed as soon as the loader is disabled.
    assign wr_o       = wr_q & enable_i;
    assign done_o     = done_q & enable_i;
    assign exec_o     = exec_q & enable_i;
    assign adr_o      = adr_q;
    assign data_o     = data_q;
    assign exec_adr_o = exec_adr_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader with a byte-FIFO model and write log.
// Latency: n/a.
// Backpressure: FIFO model can randomly drop d_avail_i to exercise stalls.
module tb_spi_frame_loader;
    import spi_frame_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        d_avail_i = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic        rd_o;
    logic [15:0] adr_o;
    logic [7:0]  data_o;
    logic        wr_o;
    logic        exec_o;
    logic [15:0] exec_adr_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    spi_frame_loader dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .d_avail_i  (d_avail_i),
        .data_i     (data_i),
        .rd_o       (rd_o),
        .adr_o      (adr_o),
        .data_o     (data_o),
        .wr_o       (wr_o),
        .exec_o     (exec_o),
        .exec_adr_o (exec_adr_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // FIFO model: main pushes into byte_mem, driver pops on observed rd_o.
    logic [7:0] byte_mem [0:511];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       stall_mode = 1'b0;
    logic       pop_seen = 1'b0;

    task automatic push(input logic [7:0] b);
        byte_mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    always begin
        @(posedge clk_i);
        #1;
        if (pop_seen) rd_ptr = rd_ptr + 1;
        d_avail_i = (rd_ptr < wr_ptr) && (!stall_mode || ($urandom_range(0, 1) == 1));
        data_i    = (rd_ptr < wr_ptr) ? byte_mem[rd_ptr] : 8'h00;
    end

    // Monitor: logs writes and pulses, counts pop-rule violations.
    logic [23:0] wr_log [$];
    int          done_cnt = 0;
    int          exec_cnt = 0;
    int          rd_viol  = 0;
    logic        prev_rd  = 1'b0;

    always @(negedge clk_i) begin
        if (wr_o) wr_log.push_back({adr_o, data_o});
        if (done_o) done_cnt <= done_cnt + 1;
        if (exec_o) exec_cnt <= exec_cnt + 1;
        if (rd_o && (!d_avail_i || !enable_i)) rd_viol <= rd_viol + 1;
        else if (rd_o && prev_rd) rd_viol <= rd_viol + 1;
        prev_rd  <= rd_o;
        pop_seen <= rd_o;
    end

    int wb, db, eb;

    task automatic mark();
        wb = wr_log.size();
        db = done_cnt;
        eb = exec_cnt;
    endtask

    function automatic logic [31:0] wr_at(input int idx);
        if (wb + idx < wr_log.size()) return {8'h00, wr_log[wb + idx]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (((rd_ptr < wr_ptr) || busy_o) && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        check_eq(tag, (n < 2000), 1'b1);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic toggle_enable();
        @(posedge clk_i); #1 enable_i = 1'b0;
        @(posedge clk_i); #1 enable_i = 1'b1;
        @(negedge clk_i);
    endtask

    logic [7:0] f_wr   [12];
    logic [7:0] f_exec [7];
    logic [7:0] f_wrap [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        f_wr   = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h10, 8'h03, 8'h00,
                   8'h11, 8'h22, 8'h33, 8'h7A};
        f_exec = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h00, 8'h00, 8'h48};
        f_wrap = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'h66};

        reset_i  = 1'b1;
        enable_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_rd",       rd_o, 1'b0);
        check_eq("rst_wr",       wr_o, 1'b0);
        check_eq("rst_exec",     exec_o, 1'b0);
        check_eq("rst_done",     done_o, 1'b0);
        check_eq("rst_busy",     busy_o, 1'b0);
        check_eq("rst_err",      err_o, 1'b0);
        check_eq("rst_adr",      adr_o, 16'h0000);
        check_eq("rst_data",     data_o, 8'h00);
        check_eq("rst_exec_adr", exec_adr_o, 16'h0000);
        check_eq("rst_state",    dut.state_q, ST_IDLE);
        @(posedge clk_i); #1;
        reset_i  = 1'b0;
        enable_i = 1'b1;

        // Idle filtering and a good WRITE frame
        mark();
        foreach (f_wr[i]) push(f_wr[i]);
        wait_idle("wr_idle");
        check_eq("wr_count", wr_log.size() - wb, 3);
        check_eq("wr0", wr_at(0), 24'h1000_11);
        check_eq("wr1", wr_at(1), 24'h1001_22);
        check_eq("wr2", wr_at(2), 24'h1002_33);
        check_eq("wr_done", done_cnt - db, 1);
        check_eq("wr_err", err_o, 1'b0);
        check_eq("wr_no_exec", exec_cnt - eb, 0);

        // Good EXEC frame
        mark();
        foreach (f_exec[i]) push(f_exec[i]);
        wait_idle("exec_idle");
        check_eq("exec_pulse", exec_cnt - eb, 1);
        check_eq("exec_adr", exec_adr_o, 16'h1234);
        check_eq("exec_no_wr", wr_log.size() - wb, 0);
        check_eq("exec_done", done_cnt - db, 1);
        check_eq("exec_err", err_o, 1'b0);

        // Bad checksum: payload still written, no done, sticky error
        mark();
        f_wr[11] = 8'h7B;
        foreach (f_wr[i]) push(f_wr[i]);
        f_wr[11] = 8'h7A;
        wait_idle("badchk_idle");
        check_eq("badchk_wr_count", wr_log.size() - wb, 3);
        check_eq("badchk_wr2", wr_at(2), 24'h1002_33);
        check_eq("badchk_done", done_cnt - db, 0);
        check_eq("badchk_err", err_o, 1'b1);

        // Address wrap; error stays set through a good frame
        mark();
        foreach (f_wrap[i]) push(f_wrap[i]);
        wait_idle("wrap_idle");
        check_eq("wrap_wr0", wr_at(0), 24'hFFFF_AA);
        check_eq("wrap_wr1", wr_at(1), 24'h0000_BB);
        check_eq("wrap_done", done_cnt - db, 1);
        check_eq("err_sticky", err_o, 1'b1);
        toggle_enable();
        check_eq("err_clear_on_disable", err_o, 1'b0);

        // Unknown command
        mark();
        push(8'hA5); push(8'h07); push(8'h00); push(8'h00);
        wait_idle("badcmd_idle");
        check_eq("badcmd_err", err_o, 1'b1);
        check_eq("badcmd_busy", busy_o, 1'b0);
        check_eq("badcmd_state", dut.state_q, ST_IDLE);
        check_eq("badcmd_no_wr", wr_log.size() - wb, 0);
        check_eq("badcmd_done", done_cnt - db, 0);
        toggle_enable();

        // Random stalls on d_avail_i
        stall_mode = 1'b1;
        mark();
        foreach (f_wr[i]) push(f_wr[i]);
        wait_idle("stall_idle");
        stall_mode = 1'b0;
        check_eq("stall_wr_count", wr_log.size() - wb, 3);
        check_eq("stall_wr0", wr_at(0), 24'h1000_11);
        check_eq("stall_wr2", wr_at(2), 24'h1002_33);
        check_eq("stall_done", done_cnt - db, 1);
        check_eq("stall_err", err_o, 1'b0);

        // Abort by dropping enable mid-DATA
        mark();
        push(8'hA5); push(8'h01); push(8'h00); push(8'h20); push(8'h04);
        push(8'h00); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        n = 0;
        while (wr_log.size() == wb && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("abort_first_wr_seen", (n < 200), 1'b1);
        @(posedge clk_i); #1 enable_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check_eq("abort_busy", busy_o, 1'b0);
        check_eq("abort_state", dut.state_q, ST_IDLE);
        repeat (20) @(negedge clk_i);
        check_eq("abort_wr_count", wr_log.size() - wb, 1);
        check_eq("abort_wr0", wr_at(0), 24'h2000_01);
        check_eq("abort_done", done_cnt - db, 0);
        @(posedge clk_i); #1 enable_i = 1'b1;
        wait_idle("abort_drain_idle");

        // Asynchronous reset while a write strobe is pending
        mark();
        push(8'hA5); push(8'h01); push(8'h00); push(8'h30);
        push(8'h02); push(8'h00); push(8'h55); push(8'h66);
        n = 0;
        while (!wr_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("rst_mid_wr_seen", wr_o, 1'b1);
        #1 reset_i = 1'b1;
        #1;
        check_eq("rst_mid_wr",   wr_o, 1'b0);
        check_eq("rst_mid_adr",  adr_o, 16'h0000);
        check_eq("rst_mid_data", data_o, 8'h00);
        check_eq("rst_mid_busy", busy_o, 1'b0);
        check_eq("rst_mid_rd",   rd_o, 1'b0);
        check_eq("rst_mid_exec_adr", exec_adr_o, 16'h0000);
        @(posedge clk_i); #1 reset_i = 1'b0;
        wait_idle("rst_drain_idle");
        check_eq("rst_drain_done", done_cnt - db, 0);

        check_eq("rd_rules", rd_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
